// File: rtl/addsub_pkg.sv
// ============================================================================
// Module      : addsub_pkg
// Description : Shared definitions for the add/sub accumulator sequencer.
//               Holds the command opcode encoding, the sequencer FSM state
//               encoding, the default datapath width and the saturation
//               constants.
//               Optional feature macro: ADDSUB_ACC_SAT_EN (used by the
//               sequencer; the saturation constants are always defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

   // Default datapath width; the external CLA adder is 8 bits wide.
   localparam int WIDTH_DEF = 8;

   // Command opcodes as presented on cmd_op.
   typedef enum logic [1:0] {
      OP_LOAD = 2'd0,
      OP_ADD  = 2'd1,
      OP_SUB  = 2'd2,
      OP_CLR  = 2'd3
   } cmd_op_e;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   // Signed saturation limits for an 8-bit two's-complement result.
   localparam logic [7:0] SAT_POS = 8'h7F;
   localparam logic [7:0] SAT_NEG = 8'h80;

endpackage : addsub_pkg

`default_nettype wire

// File: rtl/addsub_cla8.sv
// ============================================================================
// Module      : addsub_cla8
// Description : 8-bit combinational carry-look-ahead adder/subtractor.
//               op=0 : sum = a + b
//               op=1 : sum = a - b  (a + ~b + 1)
//               overflow flags signed two's-complement overflow.
// Ports       : a, b        - operands
//               op          - 0 add, 1 subtract
//               sum         - result, wraps modulo 2^8
//               overflow    - signed overflow of this operation
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_cla8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       op,
   output logic [7:0] sum,
   output logic       overflow
);

   logic [7:0] w_b_eff;
   logic [7:0] w_gen;
   logic [7:0] w_prop;
   logic [8:0] w_carry;

   assign w_b_eff = b ^ {8{op}};
   assign w_gen   = a & w_b_eff;
   assign w_prop  = a ^ w_b_eff;

   // Generate/propagate recurrence; the loop unrolls into flat
   // look-ahead carry terms.
   always_comb begin
      w_carry    = '0;
      w_carry[0] = op;
      for (int i = 0; i < 8; i++) begin
         w_carry[i+1] = w_gen[i] | (w_prop[i] & w_carry[i]);
      end
   end

   assign sum      = w_prop ^ w_carry[7:0];
   // Signed overflow: carry into the MSB differs from carry out of it.
   assign overflow = w_carry[7] ^ w_carry[8];

endmodule : addsub_cla8

`default_nettype wire

// File: rtl/addsub_acc_sequencer.sv
// ============================================================================
// Module      : addsub_acc_sequencer
// Description : Sequential front end for the external 8-bit CLA
//               adder/subtractor. Accepts LOAD/ADD/SUB/CLR commands over a
//               valid/ready handshake, holds the accumulator and operand,
//               drives the adder for one EXEC cycle, captures its sum and
//               overflow, and returns the new accumulator over a second
//               valid/ready handshake. Keeps a sticky overflow flag.
//               Optional feature macro: ADDSUB_ACC_SAT_EN - when defined,
//               overflowing ADD/SUB results saturate to 8'h7F / 8'h80.
// Ports       : clk, rst_n                    - clock, sync active-low reset
//               cmd_valid/cmd_ready/cmd_op/cmd_data - command channel
//               add_a/add_b/add_op            - to adder
//               add_sum/add_ovf               - from adder
//               res_valid/res_ready/res_data/res_ovf - result channel
//               ovf_sticky, clr_sticky        - sticky overflow and clear
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_acc_sequencer
   import addsub_pkg::*;
#(
   parameter int               WIDTH    = WIDTH_DEF,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_op,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_ovf,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_ovf,
   output logic             ovf_sticky,
   input  logic             clr_sticky
);

   state_e           state_q,    state_d;
   cmd_op_e          op_q,       op_d;
   logic [WIDTH-1:0] acc_q,      acc_d;
   logic [WIDTH-1:0] opnd_q,     opnd_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_ovf_q,  res_ovf_d;
   logic             sticky_q,   sticky_d;

   logic             w_sticky_set;
   logic [WIDTH-1:0] w_arith;

   // Adder interface follows the registers directly, so it is stable for
   // the whole EXEC cycle.
   assign add_a      = acc_q;
   assign add_b      = opnd_q;
   assign add_op     = (op_q == OP_SUB);

   assign cmd_ready  = (state_q == ST_IDLE);
   assign res_valid  = (state_q == ST_OUT);
   assign res_data   = res_data_q;
   assign res_ovf    = res_ovf_q;
   assign ovf_sticky = sticky_q;

   // Arithmetic result; overflow always comes from the adder.
   always_comb begin
      w_arith = add_sum;
`ifdef ADDSUB_ACC_SAT_EN
      if (add_ovf) begin
         // Overflow direction follows the accumulator sign.
         w_arith = acc_q[WIDTH-1] ? SAT_NEG : SAT_POS;
      end
`endif
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      acc_d        = acc_q;
      opnd_d       = opnd_q;
      res_data_d   = res_data_q;
      res_ovf_d    = res_ovf_q;
      w_sticky_set = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op_e'(cmd_op);
               opnd_d  = cmd_data;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_OUT;
            case (op_q)
               OP_ADD, OP_SUB: begin
                  acc_d        = w_arith;
                  res_data_d   = w_arith;
                  res_ovf_d    = add_ovf;
                  w_sticky_set = add_ovf;
               end
               OP_LOAD: begin
                  acc_d      = opnd_q;
                  res_data_d = opnd_q;
                  res_ovf_d  = 1'b0;
               end
               default: begin
                  acc_d      = '0;
                  res_data_d = '0;
                  res_ovf_d  = 1'b0;
               end
            endcase
         end
         ST_OUT: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new overflow outranks a same-cycle clear request.
      sticky_d = w_sticky_set | (sticky_q & ~clr_sticky);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_LOAD;
         acc_q      <= ACC_INIT;
         opnd_q     <= '0;
         res_data_q <= '0;
         res_ovf_q  <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         res_data_q <= res_data_d;
         res_ovf_q  <= res_ovf_d;
         sticky_q   <= sticky_d;
      end
   end

endmodule : addsub_acc_sequencer

`default_nettype wire

// File: doc/addsub_acc_sequencer.md
Name: addsub_acc_sequencer

Overview:
Sequential front end for the 8-bit carry-look-ahead adder/subtractor. It accepts commands over a valid/ready handshake and holds the accumulator and operand registers. It drives the adder's a/b/op inputs, captures its sum/overflow outputs, and presents the result over a second valid/ready handshake. The adder itself stays combinational and external; this block is its direct upstream and downstream neighbour.

Parameters:
WIDTH, 8, datapath width; must match the adder (8).
ACC_INIT, 8'h00, accumulator value after reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset; one clock; reset is synchronous and active-low
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  2  0=LOAD, 1=ADD, 2=SUB, 3=CLR
cmd_data  input  WIDTH  operand (ignored for CLR)
add_a  output  WIDTH  to adder a (accumulator)
add_b  output  WIDTH  to adder b (registered operand)
add_op  output  1  to adder op: 1 for SUB, else 0
add_sum  input  WIDTH  from adder sum
add_ovf  input  1  from adder overflow (signed two's-complement)
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  result value (= new accumulator)
res_ovf  output  1  this result overflowed
ovf_sticky  output  1  OR of all res_ovf since reset/clear
clr_sticky  input  1  clears ovf_sticky (one-cycle pulse)

Behaviour:
- FSM states: IDLE, EXEC, OUT. Reset -> IDLE.
- Reset values (rst_n low at clk edge): acc=ACC_INIT, operand reg=0, op reg=0, cmd_ready=1, res_valid=0, res_data=0, res_ovf=0, ovf_sticky=0. add_a/add_b/add_op follow acc/operand/op regs, so they read ACC_INIT/0/0.
- cmd_ready=1 only in IDLE. A command is accepted on a cycle with cmd_valid&&cmd_ready: latch cmd_op and cmd_data, go to EXEC.
- EXEC lasts exactly 1 cycle. add_a=acc and add_b=operand are stable for the whole cycle, with add_op=(op==SUB). At the end of the cycle:
  - ADD/SUB: acc<=add_sum, res_data<=add_sum, res_ovf<=add_ovf.
  - LOAD: acc<=operand, res_ovf<=0.
  - CLR: acc<=0, res_ovf<=0.
  - Go to OUT.
- OUT: res_valid=1. res_data/res_ovf are held stable until res_ready is sampled high, then go to IDLE. res_valid drops the next cycle.
- Latency: command accepted at cycle N, res_valid high at N+2. Minimum command period is 3 cycles.
- ovf_sticky is set on the EXEC cycle where add_ovf=1 and op is ADD/SUB. clr_sticky clears it. If set and clear occur in the same cycle, set wins.
- Arithmetic wraps modulo 2^WIDTH. Overflow is taken from the adder only, never recomputed locally.
- cmd_data/cmd_op changing while not accepted: no effect.
- Reset mid-operation (EXEC or OUT): immediate return to reset values. Any pending result is discarded.

Optional Feature:
Macro ADDSUB_ACC_SAT_EN.
- Defined: on ADD/SUB with add_ovf=1, the result saturates. acc and res_data get 8'h80 if add_a[7]=1, else 8'h7F. res_ovf and ovf_sticky are still set.
- Undefined: the wrapped add_sum is used unchanged.

Decomposition:
- Shared package addsub_pkg: cmd_op encodings (OP_LOAD, OP_ADD, OP_SUB, OP_CLR), FSM state encoding, WIDTH default, saturation constants SAT_POS=8'h7F and SAT_NEG=8'h80.
- No sub-module needed beyond the existing external adder.
- The bench instantiates this block plus the 8-bit CLA adder/subtractor wired add_a->a, add_b->b, add_op->op, sum->add_sum, overflow->add_ovf.

Test Plan:
1. Reset, then LOAD 0x05, ADD 0x03 -> res_data 0x05 then 0x08; res_ovf=0; res_valid exactly 2 cycles after each accept.
2. LOAD 0x7F, ADD 0x01 -> res_data 0x80, res_ovf=1, ovf_sticky=1 (with ADDSUB_ACC_SAT_EN: res_data 0x7F).
3. LOAD 0x80, SUB 0x01 -> res_data 0x7F, res_ovf=1 (SAT_EN: 0x80). Then CLR -> res_data 0x00, res_ovf=0, ovf_sticky still 1; pulse clr_sticky -> 0.
4. Backpressure: hold res_ready=0 for 5 cycles in OUT -> res_data stable, cmd_ready=0 throughout; command held on cmd_valid is accepted only in the cycle after the res_ready handshake.
5. Assert rst_n=0 during EXEC of ADD 0x10 -> next cycle IDLE, res_valid=0, acc=ACC_INIT, add_a=ACC_INIT.
6. Same-cycle clr_sticky and new overflow (LOAD 0x7F, ADD 0x7F, clr_sticky during EXEC) -> ovf_sticky=1, res_data 0xFE.
